mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_latency_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default parameter values for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_WIDTH            = 16;
    localparam int DEFAULT_INSTRUCTIONWIDTH = 24;
    localparam int DEFAULT_MEMLATENCY       = 1;
    localparam int DEFAULT_STARVELIMIT      = 4;

    // Access sequencing: IDLE arbitrates, ISSUE strobes the memory,
    // WAIT covers the read latency, RESP pulses the winner's ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side requests plus memory-side strobes for the port arbiter.
//
// Handshake: each requester raises its req (level) with address/write
// info stable and holds it until its ready pulses for exactly one cycle.
// In the cycle after that pulse the requester either drops req or presents
// a fresh request. Only one access is outstanding at any time, so the two
// ready pulses are never high together. memEnable is a single-cycle strobe
// per access and memWrite is only meaningful while memEnable is high.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int WIDTH            = DEFAULT_WIDTH,
    parameter int INSTRUCTIONWIDTH = DEFAULT_INSTRUCTIONWIDTH
);
    logic                        fetchReq;
    logic [WIDTH-1:0]            fetchAddress;
    logic                        fetchReady;
    logic [INSTRUCTIONWIDTH-1:0] fetchData;

    logic                        dataReq;
    logic                        dataWrite;
    logic [WIDTH-1:0]            dataAddress;
    logic [WIDTH-1:0]            dataWriteData;
    logic                        dataReady;
    logic [WIDTH-1:0]            dataReadData;

    logic                        memEnable;
    logic                        memWrite;
    logic [WIDTH-1:0]            memAddress;
    logic [WIDTH-1:0]            memWriteData;
    logic [INSTRUCTIONWIDTH-1:0] memReadData;

    // Arbiter view.
    modport slave (
        input  fetchReq, fetchAddress, dataReq, dataWrite, dataAddress,
               dataWriteData, memReadData,
        output fetchReady, fetchData, dataReady, dataReadData,
               memEnable, memWrite, memAddress, memWriteData
    );

    // Pipeline/memory environment view.
    modport master (
        output fetchReq, fetchAddress, dataReq, dataWrite, dataAddress,
               dataWriteData, memReadData,
        input  fetchReady, fetchData, dataReady, dataReadData,
               memEnable, memWrite, memAddress, memWriteData
    );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Read-latency down-counter: loaded in the ISSUE cycle, counts down in WAIT,
// and flags done when it reaches 1 (the cycle memReadData is valid).
module arb_latency_counter #(
    parameter  int MEMLATENCY  = 1,
    localparam int COUNTWIDTH  = $clog2(MEMLATENCY + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic decrement,
    output logic done
);

    logic [COUNTWIDTH-1:0] count;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= COUNTWIDTH'(MEMLATENCY);
        end else if (decrement && (count != '0)) begin
            count <= count - COUNTWIDTH'(1);
        end
    end

    assign done = (count == COUNTWIDTH'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// data loads/stores. Data wins ties unless fetch has been passed over
// STARVELIMIT times in a row.
//
// Optional build macro MEM_ARB_POSTED_WRITE_EN: stores complete in their
// ISSUE cycle (dataReady pulses there) and skip WAIT/RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int WIDTH            = DEFAULT_WIDTH,
    parameter  int INSTRUCTIONWIDTH = DEFAULT_INSTRUCTIONWIDTH,
    parameter  int MEMLATENCY       = DEFAULT_MEMLATENCY,
    parameter  int STARVELIMIT      = DEFAULT_STARVELIMIT,
    localparam int STARVEWIDTH      = $clog2(STARVELIMIT + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_port_arbiter_if.slave      bus,
    output arb_state_t             debugState,
    output logic [STARVEWIDTH-1:0] debugStarveCount
);

    arb_state_t             state;
    grant_t                 winner;
    logic                   writeFlag;
    logic [STARVEWIDTH-1:0] starveCount;
    logic                   fetchWins;
    logic                   counterLoad;
    logic                   counterDecrement;
    logic                   counterDone;

    // Fetch wins when alone, or when data has starved it long enough.
    assign fetchWins = bus.fetchReq &&
                       (!bus.dataReq || (starveCount == STARVEWIDTH'(STARVELIMIT)));

    assign counterLoad      = (state == ISSUE);
    assign counterDecrement = (state == WAIT);

    arb_latency_counter #(
        .MEMLATENCY (MEMLATENCY)
    ) latencyCounter (
        .clock     (clock),
        .reset     (reset),
        .load      (counterLoad),
        .decrement (counterDecrement),
        .done      (counterDone)
    );

    // Access sequencer; memory strobes and ready pulses are registered so
    // they are set on the transition into the cycle where they must be high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            winner           <= GRANT_FETCH;
            writeFlag        <= 1'b0;
            starveCount      <= '0;
            bus.memEnable    <= 1'b0;
            bus.memWrite     <= 1'b0;
            bus.memAddress   <= '0;
            bus.memWriteData <= '0;
            bus.fetchReady   <= 1'b0;
            bus.dataReady    <= 1'b0;
            bus.fetchData    <= '0;
            bus.dataReadData <= '0;
        end else begin
            bus.memEnable  <= 1'b0;
            bus.memWrite   <= 1'b0;
            bus.fetchReady <= 1'b0;
            bus.dataReady  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fetchReq || bus.dataReq) begin
                        bus.memEnable <= 1'b1;
                        state         <= ISSUE;
                        if (fetchWins) begin
                            winner         <= GRANT_FETCH;
                            writeFlag      <= 1'b0;
                            bus.memAddress <= bus.fetchAddress;
                            starveCount    <= '0;
                        end else begin
                            winner           <= GRANT_DATA;
                            writeFlag        <= bus.dataWrite;
                            bus.memWrite     <= bus.dataWrite;
                            bus.memAddress   <= bus.dataAddress;
                            bus.memWriteData <= bus.dataWriteData;
                            if (bus.fetchReq && (starveCount != STARVEWIDTH'(STARVELIMIT))) begin
                                starveCount <= starveCount + STARVEWIDTH'(1);
                            end
`ifdef MEM_ARB_POSTED_WRITE_EN
                            // Posted store: completion is signalled with the strobe.
                            bus.dataReady <= bus.dataWrite;
`endif
                        end
                    end
                end
                ISSUE: begin
`ifdef MEM_ARB_POSTED_WRITE_EN
                    if ((winner == GRANT_DATA) && writeFlag) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
`else
                    state <= WAIT;
`endif
                end
                WAIT: begin
                    if (counterDone) begin
                        state <= RESP;
                        if (winner == GRANT_FETCH) begin
                            bus.fetchReady <= 1'b1;
                            bus.fetchData  <= bus.memReadData;
                        end else begin
                            bus.dataReady <= 1'b1;
                            if (!writeFlag) begin
                                bus.dataReadData <= bus.memReadData[WIDTH-1:0];
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign debugState       = state;
    assign debugStarveCount = starveCount;

endmodule
